// File: rtl/mem_responder.sv
// Word-organised RAM responder for the multicycle control path: holds each access for LATENCY
// wait cycles, then pulses memReady (and memError for faulted requests). Define
// MEM_BYTE_ENABLE_EN to add a per-byte write-enable input (byteEn).
module mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
`ifdef MEM_BYTE_ENABLE_EN
    input  logic [3:0]  byteEn,
`endif
    output logic [31:0] readData,
    output logic        memReady,
    output logic        memBusy,
    output logic        memError
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0] MEM_INIT = INIT_ZERO ? 32'h0 : 32'hx;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_d;

    // Power-up contents only; reset never touches the array.
    logic [31:0] r_mem [DEPTH] = '{default: MEM_INIT};

    logic [ADDR_BITS-1:0] r_idx;
    logic [31:0]          r_wdata;
    logic                 r_write;
    logic                 r_fault;
    logic [CNT_W-1:0]     r_cnt;

    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_busy;
    logic        r_error;

    logic                 w_req;
    logic                 w_accept;
    logic [ADDR_BITS-1:0] w_in_idx;
    logic                 w_in_fault;
    logic [ADDR_BITS-1:0] w_eff_idx;
    logic [31:0]          w_eff_wdata;
    logic                 w_eff_write;
    logic                 w_eff_fault;
    logic [3:0]           w_eff_be;
    logic                 w_commit;
    logic                 w_ram_we;
    logic                 w_rd_en;
    logic                 w_ready_d;
    logic                 w_error_d;
    logic                 w_busy_d;
    logic                 w_unused;

    assign w_req      = MemRead | MemWrite;
    assign w_accept   = (r_state == StIdle) & w_req;
    assign w_in_idx   = addr[ADDR_BITS+1:2];
    assign w_in_fault = (addr[1:0] != 2'b00) | (MemRead & MemWrite);
    assign w_unused   = ^addr[31:ADDR_BITS+2];

    // With LATENCY=0 the access completes on the accept edge, so the live inputs are used.
    assign w_eff_idx   = (r_state == StIdle) ? w_in_idx   : r_idx;
    assign w_eff_wdata = (r_state == StIdle) ? writeData  : r_wdata;
    assign w_eff_write = (r_state == StIdle) ? MemWrite   : r_write;
    assign w_eff_fault = (r_state == StIdle) ? w_in_fault : r_fault;

`ifdef MEM_BYTE_ENABLE_EN
    logic [3:0] r_be;

    assign w_eff_be = (r_state == StIdle) ? byteEn : r_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_be <= 4'h0;
        end else if (w_accept) begin
            r_be <= byteEn;
        end
    end
`else
    assign w_eff_be = 4'hF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_d = (LATENCY == 0) ? StDone : StWait;
                end
            end
            StWait: begin
                if (!w_req) begin
                    w_state_d = StIdle;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_commit  = 1'b0;
        w_ram_we  = 1'b0;
        w_rd_en   = 1'b0;
        w_ready_d = 1'b0;
        w_error_d = 1'b0;
        w_busy_d  = 1'b0;
        w_commit  = (w_state_d == StDone) && (r_state != StDone);
        w_ram_we  = w_commit & w_eff_write & ~w_eff_fault & ~reset;
        w_rd_en   = w_commit & ~w_eff_write & ~w_eff_fault;
        w_ready_d = w_commit;
        w_error_d = w_commit & w_eff_fault;
        w_busy_d  = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_write <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_idx   <= w_in_idx;
                r_wdata <= writeData;
                r_write <= MemWrite;
                r_fault <= w_in_fault;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_eff_be[b]) begin
                    r_mem[w_eff_idx][8*b +: 8] <= w_eff_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rdata <= r_mem[w_eff_idx];
            end
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
            r_error <= w_error_d;
        end
    end

    assign readData = r_rdata;
    assign memReady = r_ready;
    assign memBusy  = r_busy;
    assign memError = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance for the main sequence and a
// LATENCY=0 instance for single-cycle and (with MEM_BYTE_ENABLE_EN) byte-enable writes.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        mr, mw, mr0, mw0;
    logic [31:0] a, d, a0, d0;
    logic [31:0] rdata, rdata0;
    logic        ready, busy, err, ready0, busy0, err0;
`ifdef MEM_BYTE_ENABLE_EN
    logic [3:0]  be, be0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(8), .LATENCY(2), .INIT_ZERO(1'b1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (mr),
        .MemWrite (mw),
        .addr     (a),
        .writeData(d),
`ifdef MEM_BYTE_ENABLE_EN
        .byteEn   (be),
`endif
        .readData (rdata),
        .memReady (ready),
        .memBusy  (busy),
        .memError (err)
    );

    mem_responder #(.ADDR_BITS(8), .LATENCY(0), .INIT_ZERO(1'b1)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (mr0),
        .MemWrite (mw0),
        .addr     (a0),
        .writeData(d0),
`ifdef MEM_BYTE_ENABLE_EN
        .byteEn   (be0),
`endif
        .readData (rdata0),
        .memReady (ready0),
        .memBusy  (busy0),
        .memError (err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit sel, input bit rd, input bit wr, input logic [31:0] ad,
                           input logic [31:0] dat, input logic [3:0] ben);
        if (!sel) begin
            mr = rd; mw = wr; a = ad; d = dat;
`ifdef MEM_BYTE_ENABLE_EN
            be = ben;
`endif
        end else begin
            mr0 = rd; mw0 = wr; a0 = ad; d0 = dat;
`ifdef MEM_BYTE_ENABLE_EN
            be0 = ben;
`endif
        end
    endtask

    // One full access: count edges from request to memReady, check the completion cycle and
    // the cycle after it.
    task automatic access(input string tag, input bit sel, input bit rd, input bit wr,
                          input logic [31:0] ad, input logic [31:0] dat, input logic [3:0] ben,
                          input int exp_cyc, input bit exp_err, input logic [31:0] exp_rd);
        int  cyc = 0;
        bit  seen = 1'b0;
        @(negedge clk);
        set_req(sel, rd, wr, ad, dat, ben);
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = sel ? ready0 : ready;
        end
        check({tag, "_lat"},   32'(cyc), 32'(exp_cyc));
        check({tag, "_err"},   32'(sel ? err0 : err), 32'(exp_err));
        check({tag, "_busy"},  32'(sel ? busy0 : busy), 32'd1);
        check({tag, "_rdata"}, sel ? rdata0 : rdata, exp_rd);
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(sel ? ready0 : ready), 32'd0);
        check({tag, "_idle"},  32'(sel ? busy0 : busy), 32'd0);
    endtask

    initial begin
        int pulses;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #3 reset = 1'b1;
        #20;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        access("wr10",   1'b0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0);
        access("rd10",   1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 3, 1'b0, 32'hDEADBEEF);
        access("rdmis",  1'b0, 1'b1, 1'b0, 32'h402, 32'h0,        4'hF, 3, 1'b1, 32'hDEADBEEF);
        access("wr20",   1'b0, 1'b0, 1'b1, 32'h20,  32'hA5A50008, 4'hF, 3, 1'b0, 32'hDEADBEEF);
        access("confl",  1'b0, 1'b1, 1'b1, 32'h20,  32'h0BADF00D, 4'hF, 3, 1'b1, 32'hDEADBEEF);
        access("rd20a",  1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        4'hF, 3, 1'b0, 32'hA5A50008);
        access("wrmis",  1'b0, 1'b0, 1'b1, 32'h21,  32'h77777777, 4'hF, 3, 1'b1, 32'hA5A50008);
        access("rd20b",  1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        4'hF, 3, 1'b0, 32'hA5A50008);

        // Abort: drop the write after one WAIT cycle, before it could complete.
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000CAFE, 4'hF);
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        pulses = 0;
        repeat (4) begin
            if (ready) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort_nopulse", 32'(pulses), 32'd0);
        access("rd20c",  1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        4'hF, 3, 1'b0, 32'hA5A50008);

        // Reset mid-WAIT: the aliased write to word 0 must be discarded.
        access("wr00",   1'b0, 1'b0, 1'b1, 32'h0,   32'h11110000, 4'hF, 3, 1'b0, 32'hA5A50008);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 32'h400, 32'h99999999, 4'hF);
        @(posedge clk);
        #1;
        check("rstw_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstw_rdata", rdata, 32'h0);
        check("rstw_busy0", 32'(busy), 32'd0);
        check("rstw_ready", 32'(ready), 32'd0);
        check("rstw_err",   32'(err), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        access("rd00",   1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'hF, 3, 1'b0, 32'h11110000);
        access("wr404",  1'b0, 1'b0, 1'b1, 32'h404, 32'h5A5A1234, 4'hF, 3, 1'b0, 32'h11110000);
        access("rd04",   1'b0, 1'b1, 1'b0, 32'h4,   32'h0,        4'hF, 3, 1'b0, 32'h5A5A1234);

        // Zero-latency instance.
        access("l0_wr",  1'b1, 1'b0, 1'b1, 32'h8,   32'hFFFFFFFF, 4'hF, 1, 1'b0, 32'h0);
        access("l0_wrb", 1'b1, 1'b0, 1'b1, 32'h8,   32'h12345678, 4'h3, 1, 1'b0, 32'h0);
`ifdef MEM_BYTE_ENABLE_EN
        access("l0_rdb", 1'b1, 1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 1, 1'b0, 32'hFFFF5678);
        access("l0_be0", 1'b1, 1'b0, 1'b1, 32'h8,   32'hAAAAAAAA, 4'h0, 1, 1'b0, 32'hFFFF5678);
        access("l0_rdz", 1'b1, 1'b1, 1'b0, 32'h8,   32'h0,        4'hF, 1, 1'b0, 32'hFFFF5678);
        access("l0_mis", 1'b1, 1'b1, 1'b0, 32'h9,   32'h0,        4'hF, 1, 1'b1, 32'hFFFF5678);
`else
        access("l0_rdb", 1'b1, 1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 1, 1'b0, 32'h12345678);
        access("l0_mis", 1'b1, 1'b1, 1'b0, 32'h9,   32'h0,        4'hF, 1, 1'b1, 32'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
